rr_decoder_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters. Produces an encoded grant
//   (sel_2..sel_0) plus enable (e), which drives the 3-to-8 decoder (decoder_83).
//   The decoder's one-hot outputs are the per-requester grant lines.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/decoder_83.sv | 31 +++
 rtl/rr_decoder_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter: request count,
// encoded-select width, FSM state encoding and a one-hot helper.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    // One-hot mask with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/decoder_83.sv
// 3-to-8 decoder with enable. Output q_i is high only when e=1 and the
// select code {s_2,s_1,s_0} equals i.
module decoder_83 (
    input  logic s_0,
    input  logic s_1,
    input  logic s_2,
    input  logic e,
    output logic q_0,
    output logic q_1,
    output logic q_2,
    output logic q_3,
    output logic q_4,
    output logic q_5,
    output logic q_6,
    output logic q_7
);

    logic [2:0] code;

    assign code = {s_2, s_1, s_0};

    assign q_0 = e & (code == 3'd0);
    assign q_1 = e & (code == 3'd1);
    assign q_2 = e & (code == 3'd2);
    assign q_3 = e & (code == 3'd3);
    assign q_4 = e & (code == 3'd4);
    assign q_5 = e & (code == 3'd5);
    assign q_6 = e & (code == 3'd6);
    assign q_7 = e & (code == 3'd7);

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters. Registered encoded grant (sel_2..0)
// and enable e feed a 3-to-8 decoder whose outputs are the grant lines.
// An owner is forced off after MAX_HOLD cycles when someone else waits, and
// every change of owner passes through a one-cycle gap with e=0.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             sel_0,
    output logic             sel_1,
    output logic             sel_2,
    output logic             e,
    output logic [N_REQ-1:0] gnt,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] last_ptr;
    logic [SEL_W-1:0] last_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             e_nxt;
    logic             preempt_nxt;

    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             owner_req;
    logic             others_req;
    logic             timeout;

    // Round-robin pick: rotate so index last+1 sits at bit 0, take the
    // lowest set bit, then rotate the index back.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] last);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [SEL_W:0]     shamt;
        logic [SEL_W-1:0]   enc;
        dbl   = {r, r};
        shamt = {1'b0, last} + {{SEL_W{1'b0}}, 1'b1};
        rot   = dbl[shamt +: N_REQ];
        enc   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) enc = SEL_W'(j);
        end
        return enc + last + SEL_W'(1);
    endfunction

    assign winner     = rr_pick(req, last_ptr);
    assign any_req    = |req;
    assign owner_req  = req[sel];
    assign others_req = |(req & ~onehot(sel));
    assign timeout    = (hold_cnt == HOLD_LAST);

    // State and registered outputs; reset parks on index 7 so index 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            e        <= 1'b0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            last_ptr <= SEL_W'(N_REQ - 1);
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            e        <= e_nxt;
            preempt  <= preempt_nxt;
            hold_cnt <= hold_nxt;
            last_ptr <= last_nxt;
        end
    end

    // Next-state: leave GRANT on release or on timeout with a waiting rival.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (!owner_req || (timeout && others_req)) state_nxt = GAP;
            GAP:     state_nxt = any_req ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter and pointer.
    // Leaving GRANT while the owner still requests can only be a timeout,
    // so owner_req alone marks a preemption (a drop on timeout is a release).
    always_comb begin
        sel_nxt     = sel;
        last_nxt    = last_ptr;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        e_nxt       = (state_nxt == GRANT);
        case (state)
            IDLE, GAP: begin
                if (any_req) begin
                    sel_nxt  = winner;
                    hold_nxt = '0;
                end
            end
            GRANT: begin
                if (state_nxt == GAP) begin
                    last_nxt    = sel;
                    preempt_nxt = owner_req;
                end else if (!timeout) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign sel_0 = sel[0];
    assign sel_1 = sel[1];
    assign sel_2 = sel[2];

    decoder_83 u_dec (
        .s_0 (sel_0),
        .s_1 (sel_1),
        .s_2 (sel_2),
        .e   (e),
        .q_0 (gnt[0]),
        .q_1 (gnt[1]),
        .q_2 (gnt[2]),
        .q_3 (gnt[3]),
        .q_4 (gnt[4]),
        .q_5 (gnt[5]),
        .q_6 (gnt[6]),
        .q_7 (gnt[7])
    );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter: directed scenarios followed by
// random request traffic with occasional asynchronous reset pulses.
module tb_rr_decoder_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       sel_0;
    logic       sel_1;
    logic       sel_2;
    logic       e;
    logic [7:0] gnt;
    logic       preempt;

    rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sel_0   (sel_0),
        .sel_1   (sel_1),
        .sel_2   (sel_2),
        .e       (e),
        .gnt     (gnt),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       e;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       pre;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    // Reference model: who owns the resource and for how many cycles.
    int         m_owner;
    int         m_held;
    int         m_last;
    logic [2:0] m_sel;
    logic       m_pre;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_sel   = 3'd0;
        m_pre   = 1'b0;
    endtask

    // One clock edge of the arbitration rules, given the sampled requests.
    task automatic model_step(input logic [7:0] r);
        logic [7:0] others;
        if (m_owner >= 0) begin
            others = r & ~(8'(1) << m_owner);
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_pre   = 1'b0;
            end else if (m_held >= MAX_HOLD && others != 8'h00) begin
                m_last  = m_owner;
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                if (m_held < MAX_HOLD) m_held++;
                m_pre = 1'b0;
            end
        end else begin
            m_pre = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                if (m_owner < 0 && r[(m_last + i) % 8]) m_owner = (m_last + i) % 8;
            end
            if (m_owner >= 0) begin
                m_held = 1;
                m_sel  = 3'(m_owner);
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.e   = (m_owner >= 0);
        x.sel = m_sel;
        x.gnt = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
        x.pre = m_pre;
        return x;
    endfunction

    // Drive one cycle at the falling edge and queue what the next edge must show.
    task automatic cycle(input logic [7:0] r, input logic rn);
        @(negedge clk);
        if (!rn && rst_n) begin
            model_reset();
            exp_q.push_back(model_out());
        end
        req   = r;
        rst_n = rn;
        if (!rn) model_reset();
        else     model_step(r);
        exp_q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    // Monitor: compare DUT outputs after every clock edge and reset assertion.
    initial begin
        exp_t x;
        wait (mon_en);
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: output event with no expected entry at %0t", $time);
            end else begin
                x = exp_q.pop_front();
                check("e",       {7'b0, e},                    {7'b0, x.e});
                check("sel",     {5'b0, sel_2, sel_1, sel_0},  {5'b0, x.sel});
                check("gnt",     gnt,                          x.gnt);
                check("preempt", {7'b0, preempt},              {7'b0, x.pre});
                check("gnt_onehot0", 8'($onehot0(gnt)), 8'd1);
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0] r;
        logic       rn;
        model_reset();
        // Reset held, then idle with no requests.
        repeat (2) cycle(8'h00, 1'b0);
        repeat (10) cycle(8'h00, 1'b1);
        // Single requester 2, then release.
        repeat (5) cycle(8'h04, 1'b1);
        repeat (3) cycle(8'h00, 1'b1);
        // Everyone requesting: forced rotation through all indices.
        repeat (44) cycle(8'hFF, 1'b1);
        repeat (2) cycle(8'h00, 1'b1);
        // Lone requester never preempted.
        repeat (20) cycle(8'h80, 1'b1);
        repeat (3) cycle(8'h00, 1'b1);
        // Owner 3, asynchronous reset mid-grant, restart from index 0.
        cycle(8'h08, 1'b1);
        repeat (2) cycle(8'h09, 1'b1);
        repeat (2) cycle(8'h81, 1'b0);
        repeat (4) cycle(8'h81, 1'b1);
        // Owner 1 drops exactly on its timeout cycle while 5 waits.
        cycle(8'h00, 1'b0);
        repeat (4) cycle(8'h22, 1'b1);
        repeat (4) cycle(8'h20, 1'b1);
        // Random traffic with sticky requests and rare reset pulses.
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'($urandom);
                1:       r = 8'(1) << $urandom_range(0, 7);
                2:       r = 8'h00;
                3:       r = r ^ (8'(1) << $urandom_range(0, 7));
                default: ;
            endcase
            rn = ($urandom_range(0, 80) != 0);
            cycle(r, rn);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
